// File: rtl/debounce_pkg.sv
// Shared defaults and sizing helper for the multi-channel debouncer.
// Optional long-press support is enabled with DEBOUNCE_LONGPRESS_EN.
package debounce_pkg;
  localparam int DEB_STABLE_CNT_DEF = 50000;
  localparam int DEB_CNT_W_DEF      = 16;
  localparam int DEB_LONG_CNT_DEF   = 1000000;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int deb_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction
endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: 2-flop synchroniser, stability counter, level and strobes.
// DEBOUNCE_LONGPRESS_EN adds a long-press counter and one-shot pulse.
module debounce_chan
  import debounce_pkg::*;
#(
  parameter int CNT_W      = DEB_CNT_W_DEF,
  parameter int STABLE_CNT = DEB_STABLE_CNT_DEF,
  parameter bit INIT_LEVEL = 1'b0
`ifdef DEBOUNCE_LONGPRESS_EN
  , parameter int LONG_CNT = DEB_LONG_CNT_DEF
`endif
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_button,
  output logic o_result,
  output logic o_rise,
  output logic o_fall
`ifdef DEBOUNCE_LONGPRESS_EN
  , output logic o_long_press
`endif
);
  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(STABLE_CNT - 1);

  logic             r_sync1, r_sync2, r_result, r_rise, r_fall;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1  <= INIT_LEVEL;
      r_sync2  <= INIT_LEVEL;
      r_result <= INIT_LEVEL;
      r_cnt    <= '0;
      r_rise   <= 1'b0;
      r_fall   <= 1'b0;
    end else begin
      r_sync1 <= i_button;
      r_sync2 <= r_sync1;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      // Any sample agreeing with the current level restarts the window.
      if (r_sync2 == r_result) begin
        r_cnt <= '0;
      end else if (r_cnt == C_LAST) begin
        r_result <= r_sync2;
        r_cnt    <= '0;
        r_rise   <= r_sync2;
        r_fall   <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  assign o_result = r_result;
  assign o_rise   = r_rise;
  assign o_fall   = r_fall;

`ifdef DEBOUNCE_LONGPRESS_EN
  localparam int            LW     = deb_clog2(LONG_CNT);
  localparam logic [LW-1:0] L_LAST = LW'(LONG_CNT - 1);

  logic [LW-1:0] r_lcnt;
  logic          r_fired, r_long;

  // r_fired holds off further pulses until the level drops back to 0.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lcnt  <= '0;
      r_fired <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_result) begin
        r_lcnt  <= '0;
        r_fired <= 1'b0;
      end else if (!r_fired) begin
        if (r_lcnt == L_LAST) begin
          r_long  <= 1'b1;
          r_fired <= 1'b1;
        end else begin
          r_lcnt <= r_lcnt + LW'(1);
        end
      end
    end
  end

  assign o_long_press = r_long;
`endif
endmodule

// File: rtl/debounce_multi.sv
// N_CH independent debounce channels behind one flat port list.
// DEBOUNCE_LONGPRESS_EN adds LONG_CNT and the long_press output.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int N_CH       = 4,
  parameter int CNT_W      = DEB_CNT_W_DEF,
  parameter int STABLE_CNT = DEB_STABLE_CNT_DEF,
  parameter bit INIT_LEVEL = 1'b0
`ifdef DEBOUNCE_LONGPRESS_EN
  , parameter int LONG_CNT = DEB_LONG_CNT_DEF
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] button,
  output logic [N_CH-1:0] result,
  output logic [N_CH-1:0] rise,
  output logic [N_CH-1:0] fall
`ifdef DEBOUNCE_LONGPRESS_EN
  , output logic [N_CH-1:0] long_press
`endif
);
  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_chan #(
      .CNT_W      (CNT_W),
      .STABLE_CNT (STABLE_CNT),
      .INIT_LEVEL (INIT_LEVEL)
`ifdef DEBOUNCE_LONGPRESS_EN
      , .LONG_CNT (LONG_CNT)
`endif
    ) u_chan (
      .i_clk    (clk),
      .i_rst    (rst),
      .i_button (button[g]),
      .o_result (result[g]),
      .o_rise   (rise[g]),
      .o_fall   (fall[g])
`ifdef DEBOUNCE_LONGPRESS_EN
      , .o_long_press (long_press[g])
`endif
    );
  end
endmodule

// File: tb/tb_debounce_multi.sv
// Scoreboard bench for debounce_multi (N_CH=2, STABLE_CNT=4).
// Long-press scenario compiled in only with DEBOUNCE_LONGPRESS_EN.
module tb_debounce_multi;
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] button = 2'b00;
  logic [1:0] result, rise, fall;
`ifdef DEBOUNCE_LONGPRESS_EN
  logic [1:0] long_press;
`endif

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [1:0] res;
    logic [1:0] ri;
    logic [1:0] fa;
    logic       lpchk;
    logic       lp1;
    string      nm;
  } exp_t;
  exp_t q[$];

  debounce_multi #(
    .N_CH(2), .CNT_W(3), .STABLE_CNT(4), .INIT_LEVEL(1'b0)
`ifdef DEBOUNCE_LONGPRESS_EN
    , .LONG_CNT(8)
`endif
  ) dut (
    .clk(clk), .rst(rst), .button(button),
    .result(result), .rise(rise), .fall(fall)
`ifdef DEBOUNCE_LONGPRESS_EN
    , .long_press(long_press)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [1:0] r, input logic [1:0] ri,
                      input logic [1:0] fa, input string nm);
    exp_t x;
    x.cyc = c; x.res = r; x.ri = ri; x.fa = fa; x.lpchk = 1'b0; x.lp1 = 1'b0; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic push_lp(input int c, input logic lp, input string nm);
    exp_t x;
    x.cyc = c; x.res = '0; x.ri = '0; x.fa = '0; x.lpchk = 1'b1; x.lp1 = lp; x.nm = nm;
    q.push_back(x);
  endtask

  task automatic test_reset;
    exp_t e;
    int   k;
    button = 2'b11;
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({result, rise, fall} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_immediate: got res=%b rise=%b fall=%b, expected 00/00/00", result, rise, fall);
    end
`ifdef DEBOUNCE_LONGPRESS_EN
    n_chk++;
    if (long_press !== 2'b00) begin
      n_err++;
      $display("FAIL reset_long_press: got %b, expected 00", long_press);
    end
`endif
    repeat (3) @(negedge clk);
    n_chk++;
    if ({result, rise, fall} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_held: got res=%b rise=%b fall=%b, expected 00/00/00", result, rise, fall);
    end
    rst = 1'b0;
    k = cyc;
    push(k + 5, 2'b00, 2'b00, 2'b00, "rst_before");
    push(k + 6, 2'b11, 2'b11, 2'b00, "rst_accept");
    push(k + 7, 2'b11, 2'b00, 2'b00, "rst_strobe_end");
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
    end
    if (q.size() != 0) begin n_chk++; n_err++; $display("FAIL reset_leftover: got %0d pending, expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_release;
    exp_t e;
    int   k;
    k = cyc;
    button = 2'b10;
    push(k + 5, 2'b11, 2'b00, 2'b00, "rel_before");
    push(k + 6, 2'b10, 2'b00, 2'b01, "rel_fall");
    push(k + 7, 2'b10, 2'b00, 2'b00, "rel_fall_end");
    for (int c = 8; c <= 20; c++) push(k + c, 2'b10, 2'b00, 2'b00, "rel_glitch");
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
      button = (i == 9 || i == 12) ? 2'b11 : 2'b10;
    end
    if (q.size() != 0) begin n_chk++; n_err++; $display("FAIL release_leftover: got %0d pending, expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_clean_press;
    exp_t e;
    int   k;
    k = cyc;
    button = 2'b11;
    push(k + 5, 2'b10, 2'b00, 2'b00, "press_before");
    push(k + 6, 2'b11, 2'b01, 2'b00, "press_rise");
    push(k + 7, 2'b11, 2'b00, 2'b00, "press_rise_end");
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
    end
    if (q.size() != 0) begin n_chk++; n_err++; $display("FAIL press_leftover: got %0d pending, expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_bounce;
    exp_t       e;
    int         k;
    logic [7:0] pat;
    pat = 8'b1111_0111;  // sampled LSB first: 1,1,1,0,1,1,1,1
    k = cyc;
    button = 2'b10;
    push(k + 6, 2'b10, 2'b00, 2'b01, "bnc_prep_fall");
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
    end
    k = cyc;
    button = {1'b1, pat[0]};
    for (int c = 1; c <= 9; c++) push(k + c, 2'b10, 2'b00, 2'b00, "bnc_hold");
    push(k + 10, 2'b11, 2'b01, 2'b00, "bnc_rise");
    push(k + 11, 2'b11, 2'b00, 2'b00, "bnc_single");
    push(k + 12, 2'b11, 2'b00, 2'b00, "bnc_single");
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
      button = (i < 8) ? {1'b1, pat[i]} : 2'b11;
    end
    if (q.size() != 0) begin n_chk++; n_err++; $display("FAIL bounce_leftover: got %0d pending, expected 0", q.size()); q.delete(); end
  endtask

  task automatic test_reset_mid;
    exp_t e;
    int   k;
    k = cyc;
    button = 2'b01;
    for (int c = 1; c <= 4; c++) push(k + c, 2'b11, 2'b00, 2'b00, "mid_hold");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
    end
    rst = 1'b1;
    #1;
    n_chk++;
    if ({result, rise, fall} !== 6'b0) begin
      n_err++;
      $display("FAIL mid_async_clear: got res=%b rise=%b fall=%b, expected 00/00/00", result, rise, fall);
    end
    @(negedge clk);
    rst = 1'b0;
    k = cyc;
    push(k + 5, 2'b00, 2'b00, 2'b00, "mid_before");
    push(k + 6, 2'b01, 2'b01, 2'b00, "mid_accept");
    push(k + 7, 2'b01, 2'b00, 2'b00, "mid_strobe_end");
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc <= cyc) begin
        e = q.pop_front(); n_chk++;
        if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
          n_err++;
          $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                   e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
        end
      end
    end
    if (q.size() != 0) begin n_chk++; n_err++; $display("FAIL mid_leftover: got %0d pending, expected 0", q.size()); q.delete(); end
  endtask

`ifdef DEBOUNCE_LONGPRESS_EN
  task automatic test_long;
    exp_t e;
    int   k;
    for (int ph = 0; ph < 3; ph++) begin
      k = cyc;
      if (ph == 1) begin
        button = 2'b01;
        push(k + 6, 2'b01, 2'b00, 2'b10, "lp_release");
      end else begin
        button = 2'b11;
        push(k + 6, 2'b11, 2'b10, 2'b00, "lp_result_rise");
        for (int c = 6; c <= 13; c++) push_lp(k + c, 1'b0, "lp_early");
        push_lp(k + 14, 1'b1, "lp_pulse");
        for (int c = 15; c <= 30; c++) push_lp(k + c, 1'b0, "lp_no_repeat");
      end
      for (int i = 1; i <= 30; i++) begin
        @(negedge clk);
        while (q.size() > 0 && q[0].cyc <= cyc) begin
          e = q.pop_front(); n_chk++;
          if (e.lpchk) begin
            if (e.cyc != cyc || long_press[1] !== e.lp1) begin
              n_err++;
              $display("FAIL %s cyc=%0d: got long_press[1]=%b, expected %b at cyc %0d",
                       e.nm, cyc, long_press[1], e.lp1, e.cyc);
            end
          end else if (e.cyc != cyc || {result, rise, fall} !== {e.res, e.ri, e.fa}) begin
            n_err++;
            $display("FAIL %s cyc=%0d: got res=%b rise=%b fall=%b, expected res=%b rise=%b fall=%b at cyc %0d",
                     e.nm, cyc, result, rise, fall, e.res, e.ri, e.fa, e.cyc);
          end
        end
      end
    end
    if (q.size() != 0) begin n_chk++; n_err++; $display("FAIL long_leftover: got %0d pending, expected 0", q.size()); q.delete(); end
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset;
    test_release;
    test_clean_press;
    test_bounce;
    test_reset_mid;
`ifdef DEBOUNCE_LONGPRESS_EN
    test_long;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised multi-channel successor to the single-button debouncer.
- Each channel does the following:
  - synchronises a raw mechanical input;
  - requires STABLE_CNT consecutive agreeing samples before updating its clean level;
  - emits one-cycle rise and fall strobes.
- Sits between board push-buttons/switches and the control logic on the Spartan-6 design; one instance serves all buttons.

Parameters:
- N_CH, 4: number of independent channels.
- CNT_W, 16: stability counter width; must satisfy STABLE_CNT <= 2**CNT_W.
- STABLE_CNT, 50000: consecutive stable samples required to accept a new level (>= 1); 50000 is 1 ms at 50 MHz.
- INIT_LEVEL, 0: level loaded into the synchroniser and result on reset (applies to all channels).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst  input  1  reset, asynchronous and active-high.
- button  input  N_CH  raw asynchronous button inputs.
- result  output  N_CH  debounced level per channel, registered.
- rise  output  N_CH  one-cycle pulse when result goes 0->1.
- fall  output  N_CH  one-cycle pulse when result goes 1->0.

Behaviour:
- Reset (async, active-high): per channel, sync1/sync2/result = INIT_LEVEL, cnt = 0, rise = fall = 0. Outputs take effect immediately, not at the next edge. Release is seen at the first clk edge with rst low.
- Synchroniser: two flops per channel, sync1 <= button and sync2 <= sync1. Only sync2 feeds the counter.
- Per-channel update, every edge:
  - If sync2 == result: cnt <= 0.
  - Else if cnt == STABLE_CNT-1: result <= sync2, cnt <= 0, and rise or fall <= 1 according to the new level.
  - Else: cnt <= cnt+1.
- rise and fall are 0 on every edge where result does not change. They are registered and coincident with the result transition. They are never both high on one channel.
- Latency: if button is stable from sampling edge E onward, result changes at edge E+STABLE_CNT+1.
- Glitch rejection: any sync2 sample equal to result before cnt reaches STABLE_CNT-1 clears cnt. A pulse of length < STABLE_CNT samples never propagates.
- No wrap-around: cnt never exceeds STABLE_CNT-1.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous strobes.
- Reset mid-count: the count is discarded. After release, a full STABLE_CNT+1 window is needed from the first sampled differing level.
- A button held steady through reset at a level different from INIT_LEVEL is accepted STABLE_CNT+2 edges after reset release, with the corresponding strobe.
- All outputs are flop-driven; there is no combinational path from button to any output.

Optional Feature:
- Macro: DEBOUNCE_LONGPRESS_EN.
- When defined:
  - Adds parameter LONG_CNT (default 1000000) and output long_press [N_CH].
  - A second per-channel counter runs while result == 1.
  - long_press pulses for one cycle when this counter reaches LONG_CNT-1. It fires once per press and re-arms only after result returns to 0.
  - The counter clears on result == 0 or reset; long_press resets to 0.
- When undefined: the port, parameter and counter are absent, and behaviour is otherwise identical.

Decomposition:
- Package debounce_pkg holds:
  - default constants DEB_STABLE_CNT_DEF = 50000, DEB_CNT_W_DEF = 16, DEB_LONG_CNT_DEF = 1000000;
  - a clog2-style function for sizing CNT_W.
- Sub-module debounce_chan implements one channel (synchroniser, counter, result, strobes, optional long-press). It is instantiated N_CH times in a generate loop.
- The top level only concatenates the channel outputs.

Test Plan (N_CH=2, STABLE_CNT=4, CNT_W=3, INIT_LEVEL=0, clk period 10 ns):
- Reset: rst=1 with button=2'b11 -> result=2'b00, rise=fall=2'b00 immediately; after release, result=2'b11 exactly 6 edges later, with rise=2'b11 for one cycle.
- Clean press on ch0: button[0] 0->1 sampled at edge E and held -> result[0]=1 at E+5, rise[0]=1 only during that cycle, fall=0; ch1 outputs unchanged.
- Bounce on ch0: button[0] pattern 1,1,1,0,1,1,1,1 (one sample per edge) -> no change through the 3-sample burst; result[0] rises 5 edges after the final 1-run starts; exactly one rise pulse.
- Release: button[0] 1->0 held -> result[0]=0 after 5 edges, fall[0] one cycle; 1-sample high glitches afterwards cause no strobe.
- Reset mid-count: rst pulsed after 2 stable differing samples -> result and cnt cleared asynchronously; a new full 5-edge window is required after release.
- Long press (DEBOUNCE_LONGPRESS_EN, LONG_CNT=8): button[1] held high -> long_press[1] pulses exactly once, 8 edges after result[1] rises, and does not repeat until a release-and-press cycle; without the macro the bench compiles with no long_press port.
